instr_line_buffer: RTL and testbench
====================================

INSTR_LINE_BUFFER -- requirements
Module: instr_line_buffer

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, words per buffered line; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port instr_addr_i, input, 32, the fetch address from the core's fetch stage.
REQ-005 SHALL have port flush_i, input, 1, which invalidates the buffered line (fence.i).
REQ-006 SHALL have port instr_o, output, 32, the instruction word returned to fetch.
REQ-007 SHALL have port instr_valid_o, output, 1, meaning instr_o holds the word at instr_addr_i this cycle.
REQ-008 SHALL have port misalign_o, output, 1, meaning instr_addr_i[1:0] != 0.
REQ-009 SHALL have port mem_req_o, output, 1, a word read request to backing memory.
REQ-010 SHALL have port mem_addr_o, output, 32, the word address of the request.
REQ-011 SHALL have port mem_gnt_i, input, 1, meaning the request is accepted and mem_rdata_i is valid this cycle.
REQ-012 SHALL have port mem_rdata_i, input, 32, read data from backing memory.

Function
REQ-013 SHALL hold one line: LINE_WORDS x 32-bit data, tag = addr[31:log2(LINE_WORDS)+2], line_valid bit.
REQ-014 SHALL define hit = line_valid && tag == instr_addr_i tag field && !misalign_o.
REQ-015 SHALL, on hit, drive instr_o = data[instr_addr_i word offset] and instr_valid_o = 1 combinationally in the same cycle.
REQ-016 SHALL, when not hit, drive instr_valid_o = 0 and instr_o = 32'h00000013 (NOP).
REQ-017 SHALL drive misalign_o = (instr_addr_i[1:0] != 0) combinationally; a misaligned address never starts a fill.
REQ-018 SHALL implement FSM states IDLE and FILL.
REQ-019 IDLE -> FILL: on an aligned miss at a clock edge; capture the fill tag from instr_addr_i, set word counter cnt = 0, and set line_valid = 0.
REQ-020 In FILL: mem_req_o = 1 and mem_addr_o = {fill tag, cnt, 2'b00}; both are held stable until mem_gnt_i.
REQ-021 In FILL, on mem_gnt_i: write data[cnt] <= mem_rdata_i, cnt <= cnt + 1.
REQ-022 On mem_gnt_i with cnt == LINE_WORDS-1: go to IDLE, write line tag <= fill tag, and set line_valid <= !flush_pending.
REQ-023 In IDLE: mem_req_o = 0 and mem_addr_o = 0.
REQ-024 Fill order is always word 0 to LINE_WORDS-1 (no critical-word-first), and cnt wraps to 0 on completion.
REQ-025 Changes of instr_addr_i during FILL SHALL NOT abort or retarget the fill, and instr_valid_o stays 0 throughout FILL.
REQ-026 flush_i in IDLE SHALL clear line_valid at the next edge; a hit in that same cycle is still reported.
REQ-027 flush_i in FILL SHALL set flush_pending; the fill completes, but the line is left invalid, and flush_pending is cleared when FILL completes.
REQ-028 An aligned miss in the IDLE cycle after a completed fill SHALL start a new fill (back-to-back).
REQ-029 Miss latency with mem_gnt_i held high SHALL be LINE_WORDS+1 cycles from the first miss cycle to instr_valid_o = 1.
REQ-030 No combinational path from mem_rdata_i or mem_gnt_i to instr_o or instr_valid_o.

Reset
REQ-031 With rstn = 0 at a rising edge: state = IDLE, line_valid = 0, flush_pending = 0, cnt = 0, tag = 0, data words = 0.
REQ-032 During and after reset until the first fill: mem_req_o = 0, mem_addr_o = 0, instr_valid_o = 0, instr_o = 32'h00000013.
REQ-033 Reset asserted mid-FILL SHALL abandon the fill: mem_req_o = 0 from the next cycle, and no partial line becomes valid.

Verification
REQ-034 Cold miss: after reset, addr = 0x00000000, gnt always 1, rdata = 0x11,0x22,0x33,0x44 -> mem_addr_o 0x0,0x4,0x8,0xC; instr_valid_o = 1 with instr_o = 0x11 on cycle 5.
REQ-035 Hit: after REQ-034, addr = 0x0000000C -> instr_o = 0x44 and instr_valid_o = 1 the same cycle, with mem_req_o = 0.
REQ-036 Stalled grant: addr = 0x00000020, gnt low 3 cycles per word -> mem_addr_o held at 0x20 for 4 cycles and cnt advances only on gnt.
REQ-037 Flush mid-fill: flush_i pulsed on the second word of a fill -> after the last gnt, instr_valid_o = 0 and a new fill starts at the same tag.
REQ-038 Misaligned: addr = 0x00000002 -> misalign_o = 1, instr_valid_o = 0, instr_o = 0x00000013, and mem_req_o stays 0.
REQ-039 Reset mid-fill: rstn = 0 after 2 grants, then an access to the same address -> miss and a full 4-word refill.

Source files
------------

// File: rtl/instr_line_buffer.sv
// Single-line instruction buffer in front of a word-wide backing memory.
// A hit returns the word combinationally; an aligned miss refills the whole line in order.
module instr_line_buffer #(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] instr_addr_i,
    input  logic        flush_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        misalign_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned TAG_W = 30 - OFF_W;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    state_e             state_q, state_d;
    logic               line_valid_q, line_valid_d;
    logic               flush_pend_q, flush_pend_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TAG_W-1:0]   fill_tag_q, fill_tag_d;
    logic [31:0]        data_q [LINE_WORDS];
    logic               data_we;

    logic [TAG_W-1:0]   addr_tag;
    logic [OFF_W-1:0]   addr_off;
    logic               hit;
    logic               last_word;

    assign addr_tag   = instr_addr_i[31:OFF_W+2];
    assign addr_off   = instr_addr_i[OFF_W+1:2];
    assign misalign_o = (instr_addr_i[1:0] != 2'b00);
    assign hit        = line_valid_q && (tag_q == addr_tag) && !misalign_o;
    assign last_word  = (cnt_q == OFF_W'(LINE_WORDS - 1));

    // Outputs depend only on registered line state, never on the memory response.
    assign instr_valid_o = hit;
    assign instr_o       = hit ? data_q[addr_off] : NOP;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            line_valid_q <= 1'b0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            tag_q        <= '0;
            fill_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            line_valid_q <= line_valid_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            fill_tag_q   <= fill_tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                data_q[i] <= '0;
            end
        end else if (data_we) begin
            data_q[cnt_q] <= mem_rdata_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        line_valid_d = line_valid_q;
        flush_pend_d = flush_pend_q;
        cnt_d        = cnt_q;
        tag_d        = tag_q;
        fill_tag_d   = fill_tag_q;
        data_we      = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;

        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    line_valid_d = 1'b0;
                end
                if (!hit && !misalign_o) begin
                    state_d      = FILL;
                    fill_tag_d   = addr_tag;
                    cnt_d        = '0;
                    line_valid_d = 1'b0;
                end
            end
            FILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {fill_tag_q, cnt_q, 2'b00};
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_gnt_i) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_word) begin
                        // A flush arriving on the final grant still poisons the line.
                        state_d      = IDLE;
                        tag_d        = fill_tag_q;
                        line_valid_d = !(flush_pend_q || flush_i);
                        flush_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_line_buffer.sv
// Directed bench for instr_line_buffer: a vector table for the basic flow,
// then hand-written sequences for stalls, flush-during-fill, reset-during-fill and back-to-back fills.
module tb_instr_line_buffer;

    logic        clk;
    logic        rstn;
    logic [31:0] instr_addr_i;
    logic        flush_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        misalign_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic [31:0] mem_rdata_i;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instr_line_buffer #(.LINE_WORDS(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .instr_addr_i (instr_addr_i),
        .flush_i      (flush_i),
        .instr_o      (instr_o),
        .instr_valid_o(instr_valid_o),
        .misalign_o   (misalign_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic [31:0] addr;
        logic        flush;
        logic        gnt;
        logic [31:0] rdata;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic        exp_mis;
        logic        exp_req;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic [31:0] a, input logic f, input logic g,
                       input logic [31:0] d, input logic ev, input logic [31:0] ei,
                       input logic em, input logic er, input logic [31:0] ea);
        vec_t v;
        v.rstn = r; v.addr = a; v.flush = f; v.gnt = g; v.rdata = d;
        v.exp_valid = ev; v.exp_instr = ei; v.exp_mis = em; v.exp_req = er; v.exp_maddr = ea;
        vecs.push_back(v);
    endtask

    // Apply inputs and wait until the falling edge so combinational outputs have settled.
    task automatic drive(input logic [31:0] a, input logic f, input logic g,
                         input logic [31:0] d, input logic r);
        instr_addr_i = a;
        flush_i      = f;
        mem_gnt_i    = g;
        mem_rdata_i  = d;
        rstn         = r;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] ins,
                              input logic req, input logic [31:0] ma);
        chk({tag, ".valid"}, 32'(instr_valid_o), 32'(v));
        chk({tag, ".instr"}, instr_o, ins);
        chk({tag, ".req"},   32'(mem_req_o), 32'(req));
        chk({tag, ".maddr"}, mem_addr_o, ma);
    endtask

    initial begin
        rstn = 1'b0; instr_addr_i = '0; flush_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = '0;

        //  rstn addr          fl gnt rdata        valid instr        mis req maddr
        add(0, 32'h0000_0000, 0, 0, 32'h0,        0, NOP,          0, 0, 32'h0);
        add(0, 32'h0000_0000, 0, 1, 32'h99,       0, NOP,          0, 0, 32'h0);
        add(1, 32'h0000_0000, 0, 1, 32'h99,       0, NOP,          0, 0, 32'h0);
        add(1, 32'h0000_0000, 0, 1, 32'h11,       0, NOP,          0, 1, 32'h0);
        add(1, 32'h0000_0000, 0, 1, 32'h22,       0, NOP,          0, 1, 32'h4);
        add(1, 32'h0000_0000, 0, 1, 32'h33,       0, NOP,          0, 1, 32'h8);
        add(1, 32'h0000_0000, 0, 1, 32'h44,       0, NOP,          0, 1, 32'hC);
        add(1, 32'h0000_0000, 0, 0, 32'h0,        1, 32'h11,       0, 0, 32'h0);
        add(1, 32'h0000_000C, 0, 0, 32'h0,        1, 32'h44,       0, 0, 32'h0);
        add(1, 32'h0000_0004, 0, 0, 32'h0,        1, 32'h22,       0, 0, 32'h0);
        add(1, 32'h0000_0002, 0, 1, 32'h0,        0, NOP,          1, 0, 32'h0);
        add(1, 32'h0000_0002, 0, 1, 32'h0,        0, NOP,          1, 0, 32'h0);
        add(1, 32'h0000_0008, 1, 0, 32'h0,        1, 32'h33,       0, 0, 32'h0);
        add(1, 32'h0000_0008, 0, 1, 32'h0,        0, NOP,          0, 0, 32'h0);
        add(1, 32'h0000_0008, 0, 1, 32'hA0,       0, NOP,          0, 1, 32'h0);
        add(1, 32'h0000_0100, 0, 1, 32'hA1,       0, NOP,          0, 1, 32'h4);
        add(1, 32'h0000_0008, 0, 1, 32'hA2,       0, NOP,          0, 1, 32'h8);
        add(1, 32'h0000_0008, 0, 1, 32'hA3,       0, NOP,          0, 1, 32'hC);
        add(1, 32'h0000_0008, 0, 0, 32'h0,        1, 32'hA2,       0, 0, 32'h0);

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("row%0d", i);
            drive(vecs[i].addr, vecs[i].flush, vecs[i].gnt, vecs[i].rdata, vecs[i].rstn);
            expect_out(t, vecs[i].exp_valid, vecs[i].exp_instr, vecs[i].exp_req, vecs[i].exp_maddr);
            chk({t, ".mis"}, 32'(misalign_o), 32'(vecs[i].exp_mis));
            adv();
        end

        // Stalled grant: each word address held for 3 stall cycles plus the grant cycle.
        drive(32'h20, 0, 0, 0, 1);
        expect_out("stall.miss", 0, NOP, 0, 32'h0);
        adv();
        for (int w = 0; w < 4; w++) begin
            for (int s = 0; s < 3; s++) begin
                drive(32'h20, 0, 0, 32'hDEAD, 1);
                expect_out($sformatf("stall.w%0d.s%0d", w, s), 0, NOP, 1, 32'h20 + 32'(4 * w));
                adv();
            end
            drive(32'h20, 0, 1, 32'hB0 + 32'(w), 1);
            expect_out($sformatf("stall.w%0d.g", w), 0, NOP, 1, 32'h20 + 32'(4 * w));
            adv();
        end
        drive(32'h24, 0, 0, 0, 1);
        expect_out("stall.hit1", 1, 32'hB1, 0, 32'h0);
        adv();
        drive(32'h2C, 0, 0, 0, 1);
        expect_out("stall.hit3", 1, 32'hB3, 0, 32'h0);
        adv();

        // Flush on the second word: fill completes but the line stays invalid and is refetched.
        drive(32'h40, 0, 0, 0, 1);
        adv();
        for (int w = 0; w < 4; w++) begin
            drive(32'h40, (w == 1), 1, 32'hC0 + 32'(w), 1);
            expect_out($sformatf("flush.w%0d", w), 0, NOP, 1, 32'h40 + 32'(4 * w));
            adv();
        end
        drive(32'h40, 0, 0, 0, 1);
        expect_out("flush.after", 0, NOP, 0, 32'h0);
        adv();
        for (int w = 0; w < 4; w++) begin
            drive(32'h40, 0, 1, 32'hD0 + 32'(w), 1);
            expect_out($sformatf("flush.refill%0d", w), 0, NOP, 1, 32'h40 + 32'(4 * w));
            adv();
        end
        drive(32'h44, 0, 0, 0, 1);
        expect_out("flush.hit", 1, 32'hD1, 0, 32'h0);
        adv();

        // Reset after two grants abandons the fill; the same address then misses and refills fully.
        drive(32'h60, 0, 0, 0, 1);
        adv();
        for (int w = 0; w < 2; w++) begin
            drive(32'h60, 0, 1, 32'hE0 + 32'(w), 1);
            adv();
        end
        drive(32'h60, 0, 0, 0, 0);
        expect_out("rst.pre", 0, NOP, 1, 32'h68);
        adv();
        drive(32'h60, 0, 0, 0, 0);
        expect_out("rst.in", 0, NOP, 0, 32'h0);
        adv();
        drive(32'h60, 0, 0, 0, 1);
        expect_out("rst.miss", 0, NOP, 0, 32'h0);
        adv();
        for (int w = 0; w < 4; w++) begin
            drive(32'h60, 0, 1, 32'hE0 + 32'(w), 1);
            expect_out($sformatf("rst.refill%0d", w), 0, NOP, 1, 32'h60 + 32'(4 * w));
            adv();
        end

        // Back-to-back: a miss in the first IDLE cycle after completion starts the next fill.
        drive(32'hA0, 0, 0, 0, 1);
        expect_out("b2b.miss", 0, NOP, 0, 32'h0);
        adv();
        for (int w = 0; w < 4; w++) begin
            drive(32'hA0, 0, 1, 32'hF0 + 32'(w), 1);
            expect_out($sformatf("b2b.w%0d", w), 0, NOP, 1, 32'hA0 + 32'(4 * w));
            adv();
        end
        drive(32'hAC, 0, 0, 0, 1);
        expect_out("b2b.hit", 1, 32'hF3, 0, 32'h0);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
